// File: rtl/merge_sort_scheduler_pkg.sv
// Shared definitions for merge_sort_scheduler: frame geometry, word field offsets, FSM states.
// Optional build macro SORT_EARLY_EXIT_EN is consumed by the top module.
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package merge_sort_scheduler_pkg;

    localparam int PORT_NUB_TOTAL = `PORT_NUB_TOTAL;
    localparam int DATA_WIDTH     = `DATA_WIDTH;
    localparam int ID_W           = $clog2(PORT_NUB_TOTAL);
    localparam int WIDTH_PORT     = 2 * ID_W + DATA_WIDTH;

    // Port word layout is {dst, src, data}, dst in the top bits.
    localparam int DST_MSB  = WIDTH_PORT - 1;
    localparam int SRC_MSB  = WIDTH_PORT - 1 - ID_W;
    localparam int DATA_MSB = DATA_WIDTH - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SORT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [ID_W-1:0] dst_of(input logic [WIDTH_PORT-1:0] w);
        return w[DST_MSB -: ID_W];
    endfunction

    function automatic logic [ID_W-1:0] src_of(input logic [WIDTH_PORT-1:0] w);
        return w[SRC_MSB -: ID_W];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] data_of(input logic [WIDTH_PORT-1:0] w);
        return w[DATA_MSB:0];
    endfunction

endpackage

// File: rtl/merge_sort_scheduler_cmp_exch_pair.sv
// Compare-exchange cell: orders two port words by unsigned dst, swapping only on a strict
// greater-than so equal keys keep their input order.
module cmp_exch_pair
    import merge_sort_scheduler_pkg::*;
(
    input  logic [WIDTH_PORT-1:0] a,
    input  logic [WIDTH_PORT-1:0] b,
    output logic [WIDTH_PORT-1:0] lo,
    output logic [WIDTH_PORT-1:0] hi,
    output logic                  swap
);

    assign swap = dst_of(a) > dst_of(b);
    assign lo   = swap ? b : a;
    assign hi   = swap ? a : b;

endmodule

// File: rtl/merge_sort_scheduler.sv
// Odd-even transposition sort of one frame of port words by dst, with valid/ready in and out.
// Build macro SORT_EARLY_EXIT_EN: finish after two consecutive swap-free phases.
module merge_sort_scheduler
    import merge_sort_scheduler_pkg::*;
#(
    parameter int PORT_NUB = 16,
    parameter int CNT_W    = $clog2(PORT_NUB) + 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [PORT_NUB*WIDTH_PORT-1:0] in_frame,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [PORT_NUB*WIDTH_PORT-1:0] out_frame,
    output logic                           busy,
    output logic [CNT_W-1:0]               pass_cnt
);

    localparam int FW    = PORT_NUB * WIDTH_PORT;
    localparam int HALF  = PORT_NUB / 2;

    // Handshake: a transfer happens on an edge where valid and ready are both high; valid holds
    // its payload until accepted, and ready never depends combinationally on valid.
    state_t           state;
    logic             phase;
    logic [FW-1:0]    frame;
    logic [FW-1:0]    even_next;
    logic [FW-1:0]    odd_next;
    logic [FW-1:0]    next_frame;
    logic [HALF-1:0]  even_sw;
    logic [HALF-1:0]  odd_sw;
    logic             sort_done;

    genvar k;
    generate
        for (k = 0; k < HALF; k++) begin : g_even
            cmp_exch_pair u_even (
                .a    (frame[(2*k)*WIDTH_PORT +: WIDTH_PORT]),
                .b    (frame[(2*k+1)*WIDTH_PORT +: WIDTH_PORT]),
                .lo   (even_next[(2*k)*WIDTH_PORT +: WIDTH_PORT]),
                .hi   (even_next[(2*k+1)*WIDTH_PORT +: WIDTH_PORT]),
                .swap (even_sw[k])
            );
        end
        for (k = 0; k < HALF - 1; k++) begin : g_odd
            cmp_exch_pair u_odd (
                .a    (frame[(2*k+1)*WIDTH_PORT +: WIDTH_PORT]),
                .b    (frame[(2*k+2)*WIDTH_PORT +: WIDTH_PORT]),
                .lo   (odd_next[(2*k+1)*WIDTH_PORT +: WIDTH_PORT]),
                .hi   (odd_next[(2*k+2)*WIDTH_PORT +: WIDTH_PORT]),
                .swap (odd_sw[k])
            );
        end
    endgenerate

    // The end ports have no partner in the odd phase.
    assign odd_next[WIDTH_PORT-1:0]   = frame[WIDTH_PORT-1:0];
    assign odd_next[FW-1 -: WIDTH_PORT] = frame[FW-1 -: WIDTH_PORT];
    assign odd_sw[HALF-1]             = 1'b0;

    assign next_frame = phase ? odd_next : even_next;
    assign out_frame  = frame;

`ifdef SORT_EARLY_EXIT_EN
    logic       any_swap;
    logic [1:0] zero_run;

    assign any_swap  = phase ? (|odd_sw) : (|even_sw);
    assign sort_done = (pass_cnt == CNT_W'(PORT_NUB)) || (zero_run == 2'd2);
`else
    wire unused_swaps = |{even_sw, odd_sw};

    assign sort_done = (pass_cnt == CNT_W'(PORT_NUB));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            frame     <= '0;
            pass_cnt  <= '0;
            phase     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef SORT_EARLY_EXIT_EN
            zero_run  <= 2'd0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        frame    <= in_frame;
                        pass_cnt <= '0;
                        phase    <= 1'b0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_SORT;
`ifdef SORT_EARLY_EXIT_EN
                        zero_run <= 2'd0;
`endif
                    end
                end
                ST_SORT: begin
                    if (sort_done) begin
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        frame <= next_frame;
                        phase <= ~phase;
                        if (pass_cnt != CNT_W'(PORT_NUB))
                            pass_cnt <= pass_cnt + CNT_W'(1);
`ifdef SORT_EARLY_EXIT_EN
                        if (any_swap)
                            zero_run <= 2'd0;
                        else if (zero_run != 2'd2)
                            zero_run <= zero_run + 2'd1;
`endif
                    end
                end
                ST_DONE: begin
                    // Frame and pass_cnt are left untouched so the last result stays visible.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_merge_sort_scheduler.sv
// Directed bench for merge_sort_scheduler: reset, reverse, stability, backpressure,
// pre-sorted latency, mid-sort reset and a batch of random frames against a stable-sort model.
`timescale 1ns/1ps
module tb_merge_sort_scheduler;
    import merge_sort_scheduler_pkg::*;

    localparam int N     = 16;
    localparam int W     = WIDTH_PORT;
    localparam int FW    = N * W;
    localparam int CNT_W = $clog2(N) + 1;
`ifdef SORT_EARLY_EXIT_EN
    localparam int SHORT_LAT = 3;
    localparam int SHORT_CNT = 2;
`else
    localparam int SHORT_LAT = 17;
    localparam int SHORT_CNT = 16;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [FW-1:0]    in_frame = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [FW-1:0]    out_frame;
    logic             busy;
    logic [CNT_W-1:0] pass_cnt;

    int errors = 0;
    int checks = 0;

    merge_sort_scheduler #(.PORT_NUB(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_frame  (in_frame),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_frame (out_frame),
        .busy      (busy),
        .pass_cnt  (pass_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input int d, input int s, input int x);
        return {4'(d), 4'(s), 8'(x)};
    endfunction

    // Reference: stable insertion sort on dst.
    function automatic logic [FW-1:0] model_sort(input logic [FW-1:0] f);
        logic [W-1:0]  w [N];
        logic [W-1:0]  t;
        logic [FW-1:0] r;
        for (int i = 0; i < N; i++) w[i] = f[i*W +: W];
        for (int i = 1; i < N; i++)
            for (int j = i; j > 0; j--)
                if (w[j-1][W-1 -: 4] > w[j][W-1 -: 4]) begin
                    t = w[j]; w[j] = w[j-1]; w[j-1] = t;
                end
        for (int i = 0; i < N; i++) r[i*W +: W] = w[i];
        return r;
    endfunction

    task automatic send_frame(input logic [FW-1:0] f);
        for (int i = 0; i < 50 && !in_ready; i++) begin
            @(posedge clk); #1;
        end
        chk("accept_ready", FW'(in_ready), FW'(1));
        in_valid = 1'b1;
        in_frame = f;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    logic [FW-1:0] fin, fexp, fother;
    int lat;
    int received;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", FW'(in_ready), FW'(1));
        chk("rst_out_valid", FW'(out_valid), FW'(0));
        chk("rst_busy", FW'(busy), FW'(0));
        chk("rst_frame", out_frame, '0);
        chk("rst_pass_cnt", FW'(pass_cnt), FW'(0));

        // Reverse frame: port i dst=15-i data=i
        for (int i = 0; i < N; i++) begin
            fin[i*W +: W]  = mk(15 - i, i, i);
            fexp[i*W +: W] = mk(i, 15 - i, 15 - i);
        end
        send_frame(fin);
        chk("rev_busy", FW'(busy), FW'(1));
        wait_done(lat);
        chk("rev_latency", FW'(lat), FW'(17));
        chk("rev_frame", out_frame, fexp);
        chk("rev_pass_cnt", FW'(pass_cnt), FW'(16));
        chk("rev_busy_done", FW'(busy), FW'(0));
        chk("rev_in_ready_done", FW'(in_ready), FW'(0));
        consume();
        chk("rev_out_valid_after", FW'(out_valid), FW'(0));
        chk("rev_in_ready_after", FW'(in_ready), FW'(1));
        chk("rev_frame_hold", out_frame, fexp);
        chk("rev_cnt_hold", FW'(pass_cnt), FW'(16));

        // Stability: all dst equal
        for (int i = 0; i < N; i++) fin[i*W +: W] = mk(5, i, i);
        send_frame(fin);
        wait_done(lat);
        chk("stable_latency", FW'(lat), FW'(SHORT_LAT));
        chk("stable_frame", out_frame, fin);
        chk("stable_pass_cnt", FW'(pass_cnt), FW'(SHORT_CNT));
        consume();

        // Backpressure: dst = 7*i mod 16, sorted port j originates from port 7*j mod 16
        for (int i = 0; i < N; i++) begin
            fin[i*W +: W]    = mk((7 * i) % 16, i, i + 64);
            fexp[i*W +: W]   = mk(i, (7 * i) % 16, (7 * i) % 16 + 64);
            fother[i*W +: W] = mk(i, i, 255);
        end
        send_frame(fin);
        wait_done(lat);
        chk("bp_latency", FW'(lat), FW'(17));
        in_valid = 1'b1;
        in_frame = fother;
        for (int c = 0; c < 10; c++) begin
            chk("bp_out_valid", FW'(out_valid), FW'(1));
            chk("bp_frame", out_frame, fexp);
            chk("bp_in_ready", FW'(in_ready), FW'(0));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        consume();
        chk("bp_released", FW'(out_valid), FW'(0));
        chk("bp_frame_after", out_frame, fexp);

        // Pre-sorted frame
        for (int i = 0; i < N; i++) fin[i*W +: W] = mk(i, 15 - i, 3 * i);
        send_frame(fin);
        wait_done(lat);
        chk("presorted_latency", FW'(lat), FW'(SHORT_LAT));
        chk("presorted_frame", out_frame, fin);
        chk("presorted_pass_cnt", FW'(pass_cnt), FW'(SHORT_CNT));
        consume();

        // Reset asserted mid-sort
        for (int i = 0; i < N; i++) fin[i*W +: W] = mk(15 - i, i, i);
        send_frame(fin);
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_busy_before", FW'(busy), FW'(1));
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_in_ready", FW'(in_ready), FW'(1));
        chk("midrst_out_valid", FW'(out_valid), FW'(0));
        chk("midrst_busy", FW'(busy), FW'(0));
        chk("midrst_frame", out_frame, '0);
        chk("midrst_pass_cnt", FW'(pass_cnt), FW'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Random frames with random consumer stalls
        received = 0;
        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < N; i++)
                fin[i*W +: W] = mk($urandom_range(0, 15), i, $urandom_range(0, 255));
            fexp = model_sort(fin);
            send_frame(fin);
            wait_done(lat);
            chk("rnd_done", FW'(out_valid), FW'(1));
            chk("rnd_frame", out_frame, fexp);
            for (int s = $urandom_range(0, 3); s > 0; s--) begin
                @(posedge clk); #1;
                chk("rnd_stall_frame", out_frame, fexp);
            end
            if (out_valid) received++;
            consume();
        end
        chk("rnd_received", FW'(received), FW'(20));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
